// File: rtl/score_keeper.sv
// score_keeper: rhythm-game score, combo, multiplier and health tracker.
// A start pulse (re)begins a song; hit/miss pulses update the counters
// while playing. Health reaching zero ends the song in FAILED.
// Optional feature: define SCORE_BEST_COMBO_EN to track best_combo;
// otherwise best_combo is tied to zero and no register is built for it.
module score_keeper #(
  parameter int HEALTH_INIT = 8,
  parameter int HEALTH_MAX  = 15,
  parameter int MISS_COST   = 2,
  parameter int COMBO_STEP  = 8
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  output logic [7:0] score,
  output logic [7:0] combo,
  output logic [2:0] multiplier,
  output logic [3:0] health,
  output logic       playing,
  output logic       failed,
  output logic [7:0] best_combo
);

  localparam logic [3:0] HEALTH_INIT_C = 4'(HEALTH_INIT);
  localparam logic [3:0] HEALTH_MAX_C  = 4'(HEALTH_MAX);
  localparam logic [4:0] MISS_COST_C   = 5'(MISS_COST);
  localparam logic [3:0] MISS_COST_LO  = 4'(MISS_COST);
  localparam logic [7:0] COMBO_STEP_C  = 8'(COMBO_STEP);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_FAILED = 2'd2
  } state_t;

  state_t      state_r;
  logic [7:0]  score_r;
  logic [7:0]  combo_r;
  logic [3:0]  health_r;

  logic [7:0]  steps_s;
  logic [2:0]  multiplier_s;
  logic [8:0]  score_sum_s;
  logic [8:0]  combo_sum_s;
  logic [4:0]  health_sum_s;
  logic [7:0]  score_hit_s;
  logic [7:0]  combo_hit_s;
  logic [3:0]  health_hit_s;
  logic [3:0]  health_miss_s;
  logic        hit_only_s;

  // Multiplier steps up every COMBO_STEP consecutive hits, capped at 4.
  always_comb begin
    steps_s = combo_r / COMBO_STEP_C;
    if (steps_s >= 8'd3) begin
      multiplier_s = 3'd4;
    end else begin
      multiplier_s = steps_s[2:0] + 3'd1;
    end
  end

  // Saturating next values, computed on widened sums so nothing wraps.
  always_comb begin
    score_sum_s  = {1'b0, score_r} + {6'd0, multiplier_s};
    combo_sum_s  = {1'b0, combo_r} + 9'd1;
    health_sum_s = {1'b0, health_r} + 5'd1;

    if (score_sum_s > 9'd255) begin
      score_hit_s = 8'd255;
    end else begin
      score_hit_s = score_sum_s[7:0];
    end

    if (combo_sum_s > 9'd255) begin
      combo_hit_s = 8'd255;
    end else begin
      combo_hit_s = combo_sum_s[7:0];
    end

    if (health_sum_s > {1'b0, HEALTH_MAX_C}) begin
      health_hit_s = HEALTH_MAX_C;
    end else begin
      health_hit_s = health_sum_s[3:0];
    end

    if ({1'b0, health_r} <= MISS_COST_C) begin
      health_miss_s = 4'd0;
    end else begin
      health_miss_s = health_r - MISS_COST_LO;
    end
  end

  // A hit only counts when no miss arrives in the same cycle.
  assign hit_only_s = hit & ~miss;

  // Song state machine and counters; start overrides any hit/miss.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_r  <= ST_IDLE;
      score_r  <= 8'd0;
      combo_r  <= 8'd0;
      health_r <= 4'd0;
    end else if (start) begin
      state_r  <= ST_PLAY;
      score_r  <= 8'd0;
      combo_r  <= 8'd0;
      health_r <= HEALTH_INIT_C;
    end else begin
      case (state_r)
        ST_PLAY: begin
          if (miss) begin
            combo_r  <= 8'd0;
            health_r <= health_miss_s;
            if (health_miss_s == 4'd0) begin
              state_r <= ST_FAILED;
            end
          end else if (hit) begin
            score_r  <= score_hit_s;
            combo_r  <= combo_hit_s;
            health_r <= health_hit_s;
          end
        end
        ST_IDLE:   state_r <= ST_IDLE;
        ST_FAILED: state_r <= ST_FAILED;
        default:   state_r <= ST_IDLE;
      endcase
    end
  end

`ifdef SCORE_BEST_COMBO_EN
  logic [7:0] best_combo_r;

  // Remember the longest combo of the current song.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      best_combo_r <= 8'd0;
    end else if (start) begin
      best_combo_r <= 8'd0;
    end else if ((state_r == ST_PLAY) && hit_only_s && (combo_hit_s > best_combo_r)) begin
      best_combo_r <= combo_hit_s;
    end
  end

  assign best_combo = best_combo_r;
`else
  assign best_combo = 8'd0;
`endif

  assign score      = score_r;
  assign combo      = combo_r;
  assign health     = health_r;
  assign multiplier = multiplier_s;
  assign playing    = (state_r == ST_PLAY);
  assign failed     = (state_r == ST_FAILED);

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against
// an integer-arithmetic reference model of the game rules.
module tb_score_keeper;

  localparam int H_INIT = 8;
  localparam int H_MAX  = 15;
  localparam int M_COST = 2;
  localparam int C_STEP = 8;

  logic       clk;
  logic       reset_b;
  logic       start;
  logic       hit;
  logic       miss;
  logic [7:0] score;
  logic [7:0] combo;
  logic [2:0] multiplier;
  logic [3:0] health;
  logic       playing;
  logic       failed;
  logic [7:0] best_combo;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 0;

  // reference model: 0 = idle, 1 = play, 2 = failed
  int m_state, m_score, m_combo, m_health, m_best;

  score_keeper dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .start      (start),
    .hit        (hit),
    .miss       (miss),
    .score      (score),
    .combo      (combo),
    .multiplier (multiplier),
    .health     (health),
    .playing    (playing),
    .failed     (failed),
    .best_combo (best_combo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int model_mult();
    return 1 + imin(m_combo / C_STEP, 3);
  endfunction

  function automatic int model_best();
`ifdef SCORE_BEST_COMBO_EN
    return m_best;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game rules applied to the model for one clock edge.
  task automatic model_step(input bit rb, input bit s, input bit h, input bit m);
    if (!rb) begin
      m_state = 0; m_score = 0; m_combo = 0; m_health = 0; m_best = 0;
    end else if (s) begin
      m_state = 1; m_score = 0; m_combo = 0; m_health = H_INIT; m_best = 0;
    end else if (m_state == 1) begin
      if (m) begin
        m_combo  = 0;
        m_health = imax(m_health - M_COST, 0);
        if (m_health == 0) m_state = 2;
      end else if (h) begin
        m_score  = imin(m_score + model_mult(), 255);
        m_combo  = imin(m_combo + 1, 255);
        m_best   = imax(m_best, m_combo);
        m_health = imin(m_health + 1, H_MAX);
      end
    end
  endtask

  // One clock: drive on the falling edge, let the compare process run, then return.
  task automatic cyc(input bit rb, input bit s, input bit h, input bit m);
    @(negedge clk);
    reset_b = rb; start = s; hit = h; miss = m;
    model_step(rb, s, h, m);
    @(posedge clk);
    #2;
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  // Compare every DUT output against the model shortly after each rising edge.
  always @(posedge clk) begin
    #1;
    if (check_en) begin
      check("score",      int'(score),      m_score);
      check("combo",      int'(combo),      m_combo);
      check("multiplier", int'(multiplier), model_mult());
      check("health",     int'(health),     m_health);
      check("playing",    int'(playing),    (m_state == 1) ? 1 : 0);
      check("failed",     int'(failed),     (m_state == 2) ? 1 : 0);
      check("best_combo", int'(best_combo), model_best());
    end
  end

  initial begin
    int r;
    reset_b = 1'b0; start = 1'b0; hit = 1'b0; miss = 1'b0;
    m_state = 0; m_score = 0; m_combo = 0; m_health = 0; m_best = 0;

    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_en = 1;
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check("rst_score", int'(score), 0);
    check("rst_health", int'(health), 0);
    check("rst_mult", int'(multiplier), 1);
    check("rst_playing", int'(playing), 0);

    // eight hits reach the second multiplier step
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    hits(8);
    check("h8_score", int'(score), 8);
    check("h8_combo", int'(combo), 8);
    check("h8_mult", int'(multiplier), 2);
    check("h8_health", int'(health), 15);
    hits(1);
    check("h9_score", int'(score), 10);

    // five hits then a miss
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    hits(5);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("miss_combo", int'(combo), 0);
    check("miss_mult", int'(multiplier), 1);
    check("miss_health", int'(health), 11);
    check("miss_score", int'(score), 5);
`ifdef SCORE_BEST_COMBO_EN
    check("miss_best", int'(best_combo), 5);
`else
    check("miss_best", int'(best_combo), 0);
`endif

    // four misses drain health and fail the song
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1); check("drain1", int'(health), 6);
    cyc(1'b1, 1'b0, 1'b0, 1'b1); check("drain2", int'(health), 4);
    cyc(1'b1, 1'b0, 1'b0, 1'b1); check("drain3", int'(health), 2);
    check("drain3_failed", int'(failed), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1); check("drain4", int'(health), 0);
    check("drain4_failed", int'(failed), 1);
    hits(1);
    check("failed_score", int'(score), 0);
    check("failed_combo", int'(combo), 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("restart_playing", int'(playing), 1);
    check("restart_health", int'(health), 8);

    // simultaneous hit and miss acts as a miss
    hits(3);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    check("both_combo", int'(combo), 0);
    check("both_score", int'(score), 3);
    check("both_health", int'(health), 9);

    // long run: multiplier cap and saturation of score and combo
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    hits(24);
    check("c24_mult", int'(multiplier), 4);
    check("c24_score", int'(score), 48);
    hits(16);
    check("c40_score", int'(score), 112);
    hits(220);
    check("sat_score", int'(score), 255);
    check("sat_combo", int'(combo), 255);

    // reset in the middle of a song
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    hits(14);
    check("pre_rst_score", int'(score), 20);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("mid_rst_score", int'(score), 0);
    check("mid_rst_combo", int'(combo), 0);
    check("mid_rst_health", int'(health), 0);
    check("mid_rst_playing", int'(playing), 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit rb, s, h, m;
      r  = int'($urandom_range(0, 999));
      rb = (r >= 4);
      s  = ($urandom_range(0, 79) == 0);
      h  = ($urandom_range(0, 1) == 1);
      m  = ($urandom_range(0, 9) == 0);
      cyc(rb, s, h, m);
    end

    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter HEALTH_INIT, default 8, meaning health loaded on start.
REQ-002 SHALL have parameter HEALTH_MAX, default 15, meaning health saturation ceiling.
REQ-003 SHALL have parameter MISS_COST, default 2, meaning health lost per miss.
REQ-004 SHALL have parameter COMBO_STEP, default 8, meaning consecutive hits per multiplier step.
REQ-005 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-006 SHALL have port reset_b  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port start  input  1  one-cycle pulse, begins or restarts a song.
REQ-008 SHALL have port hit  input  1  one-cycle pulse from hit detector, note struck in window.
REQ-009 SHALL have port miss  input  1  one-cycle pulse, note left hit window unstruck.
REQ-010 SHALL have port score  output  8  accumulated points.
REQ-011 SHALL have port combo  output  8  consecutive hits since last miss.
REQ-012 SHALL have port multiplier  output  3  current point multiplier, 1..4.
REQ-013 SHALL have port health  output  4  remaining health.
REQ-014 SHALL have port playing  output  1  high in PLAY state.
REQ-015 SHALL have port failed  output  1  high in FAILED state.
REQ-016 SHALL have port best_combo  output  8  highest combo reached since start.

Function
REQ-017 SHALL implement FSM states IDLE, PLAY, FAILED; playing = (state==PLAY), failed = (state==FAILED).
REQ-018 SHALL, on start in any state: go to PLAY, score=0, combo=0, best_combo=0, health=HEALTH_INIT.
REQ-019 SHALL ignore hit and miss outside PLAY; start in same cycle as hit/miss takes priority, event dropped.
REQ-020 SHALL compute multiplier = 1 + min(combo / COMBO_STEP, 3) combinationally from the combo register.
REQ-021 SHALL, on hit alone in PLAY: score += multiplier (pre-hit value), saturating at 255; combo += 1, saturating at 255; health += 1, saturating at HEALTH_MAX.
REQ-022 SHALL, on miss in PLAY: combo=0; health -= MISS_COST, floored at 0; score unchanged.
REQ-023 SHALL treat hit and miss in the same cycle as miss only.
REQ-024 SHALL transition PLAY to FAILED on the edge where health reaches 0; FAILED holds all counters until start.
REQ-025 SHALL update all registered outputs one clock after the triggering input edge (latency 1).
REQ-026 SHALL update best_combo to combo's new value whenever the new combo exceeds best_combo.
REQ-027 SHALL perform saturation using widened intermediate sums, never wrapping.

Reset
REQ-028 SHALL, with reset_b low at a clock edge: state=IDLE, score=0, combo=0, best_combo=0, health=0; multiplier therefore 1.
REQ-029 SHALL give reset_b priority over start, hit and miss, including mid-song.

Configuration
REQ-030 SHALL compile best_combo tracking only when SCORE_BEST_COMBO_EN is defined.
REQ-031 SHALL, with SCORE_BEST_COMBO_EN undefined, drive best_combo constant 0 and instantiate no best-combo register; all other behaviour identical.

Verification
REQ-032 SHALL cover: reset, start, 8 hits -> score=8, combo=8, multiplier=2, health=15; 9th hit -> score=10.
REQ-033 SHALL cover: start, 5 hits, miss -> combo=0, multiplier=1, health=11, score=5, best_combo=5 (0 if macro undefined).
REQ-034 SHALL cover: start, 4 misses -> health 6,4,2,0, failed=1 after 4th; further hit -> score/combo unchanged; start -> playing=1, health=8.
REQ-035 SHALL cover: hit and miss same cycle with combo=3 -> combo=0, score unchanged, health decremented by 2.
REQ-036 SHALL cover: 40 hits -> multiplier=4 from combo 24, score saturates at 255 with no wrap; combo saturates at 255 after 255+ hits.
REQ-037 SHALL cover: reset_b low mid-song with score=20 -> next cycle all outputs at reset values, playing=0.
